// File: rtl/oddr_gbx_pkg.sv
// Shared types and sizing helpers for the ODDR TX gearbox.
// State PRE is only reachable when ODDR_GBX_PREAMBLE_EN is defined.
package oddr_gbx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PRE   = 2'd3
    } gbx_state_t;

    function automatic int unsigned beats_f(input int unsigned data_w);
        return data_w / 2;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned data_w);
        return $clog2(beats_f(data_w));
    endfunction

endpackage

// File: rtl/oddr_gbx_shifter.sv
// Word shift register and beat counter; presents the current DDR bit pair.
// Bit order (LSB or MSB first) is resolved here so the top stays order-agnostic.
module oddr_gbx_shifter
    import oddr_gbx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_advance,
    output logic              o_d0,
    output logic              o_d1,
    output logic              o_last_beat
);

    localparam int unsigned BEATS = beats_f(DATA_W);
    localparam int unsigned CNT_W = cnt_w_f(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_shift_next;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign w_shift_next = {2'b00, r_shift[DATA_W-1:2]};
            assign o_d0         = r_shift[0];
            assign o_d1         = r_shift[1];
        end else begin : g_msb
            assign w_shift_next = {r_shift[DATA_W-3:0], 2'b00};
            assign o_d0         = r_shift[DATA_W-1];
            assign o_d1         = r_shift[DATA_W-2];
        end
    endgenerate

    assign o_last_beat = (r_cnt == LAST_CNT);

    // A load on the last beat wins over the advance, giving a seamless reload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
        end else if (i_advance) begin
            r_shift <= w_shift_next;
            r_cnt   <= o_last_beat ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/oddr_tx_gearbox.sv
// Parallel-to-DDR gearbox driving ODDR D0/D1/TX from a valid/ready word stream.
// Define ODDR_GBX_PREAMBLE_EN to emit PRE_BEATS cycles of PRE_PAT before each frame.
module oddr_tx_gearbox
    import oddr_gbx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic        INIT      = 1'b0,
    parameter int unsigned PRE_BEATS = 2,
    parameter logic [1:0]  PRE_PAT   = 2'b10
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              S_TVALID,
    output logic              S_TREADY,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TLAST,
    output logic              D0_O,
    output logic              D1_O,
    output logic              TX_O,
    output logic              UNDERRUN,
    output logic              BUSY
);

    gbx_state_t r_state;
    logic       r_tlast;
    logic       r_d0;
    logic       r_d1;
    logic       r_tx;
    logic       r_underrun;
    logic       r_under_pend;

    logic       w_d0;
    logic       w_d1;
    logic       w_last_beat;
    logic       w_xfer;

`ifdef ODDR_GBX_PREAMBLE_EN
    localparam logic [3:0] PRE_LAST = 4'(PRE_BEATS - 1);
    logic [3:0] r_pre_cnt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{PRE_PAT, PRE_BEATS[3:0]};
`endif

    assign S_TREADY = (r_state == ST_IDLE) || (r_state == ST_HOLD) ||
                      ((r_state == ST_SHIFT) && w_last_beat && !r_tlast);
    assign w_xfer   = S_TVALID && S_TREADY;
    assign BUSY     = (r_state != ST_IDLE);
    assign D0_O     = r_d0;
    assign D1_O     = r_d1;
    assign TX_O     = r_tx;
    assign UNDERRUN = r_underrun;

    oddr_gbx_shifter #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_load      (w_xfer),
        .i_word      (S_TDATA),
        .i_advance   (r_state == ST_SHIFT),
        .o_d0        (w_d0),
        .o_d1        (w_d1),
        .o_last_beat (w_last_beat)
    );

    // Output stage lags the state by one cycle, so UNDERRUN is staged to line up with HOLD on the pins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_tlast      <= 1'b0;
            r_d0         <= INIT;
            r_d1         <= INIT;
            r_tx         <= 1'b1;
            r_underrun   <= 1'b0;
            r_under_pend <= 1'b0;
`ifdef ODDR_GBX_PREAMBLE_EN
            r_pre_cnt    <= '0;
`endif
        end else begin
            r_underrun   <= r_under_pend;
            r_under_pend <= 1'b0;
            case (r_state)
                ST_SHIFT: begin
                    r_d0 <= w_d0;
                    r_d1 <= w_d1;
                    r_tx <= 1'b0;
                    if (w_last_beat) begin
                        if (r_tlast) begin
                            r_state <= ST_IDLE;
                        end else if (w_xfer) begin
                            r_tlast <= S_TLAST;
                        end else begin
                            r_state      <= ST_HOLD;
                            r_under_pend <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    r_d0 <= INIT;
                    r_d1 <= INIT;
                    r_tx <= 1'b0;
                    if (w_xfer) begin
                        r_tlast <= S_TLAST;
                        r_state <= ST_SHIFT;
                    end
                end
`ifdef ODDR_GBX_PREAMBLE_EN
                ST_PRE: begin
                    r_d0 <= PRE_PAT[0];
                    r_d1 <= PRE_PAT[1];
                    r_tx <= 1'b0;
                    if (r_pre_cnt == PRE_LAST) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 4'd1;
                    end
                end
`endif
                default: begin
                    r_d0 <= INIT;
                    r_d1 <= INIT;
                    r_tx <= 1'b1;
                    if (w_xfer) begin
                        r_tlast <= S_TLAST;
`ifdef ODDR_GBX_PREAMBLE_EN
                        r_state   <= ST_PRE;
                        r_pre_cnt <= '0;
`else
                        r_state   <= ST_SHIFT;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oddr_tx_gearbox.sv
// Directed bench for oddr_tx_gearbox: LSB-first and MSB-first instances share one stimulus stream.
// Expected beats are queued at each accepted transfer and checked on the cycle they are due.
module tb_oddr_tx_gearbox;

`ifdef ODDR_GBX_PREAMBLE_EN
    localparam int PRE_OFF = 2;
`else
    localparam int PRE_OFF = 0;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] l;
        logic [1:0] m;
    } beat_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       S_TVALID;
    logic [7:0] S_TDATA;
    logic       S_TLAST;
    logic       S_TREADY, D0_O, D1_O, TX_O, UNDERRUN, BUSY;
    logic       m_tready, m_d0, m_d1, m_tx, m_underrun, m_busy;

    int    n_vec = 0;
    int    n_miss = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    bit    got = 0;
    bit    frame_open = 0;
    beat_t q[$];

    always #5 CLK = ~CLK;

    oddr_tx_gearbox #(
        .DATA_W(8), .LSB_FIRST(1'b1), .INIT(1'b0), .PRE_BEATS(2), .PRE_PAT(2'b10)
    ) u_lsb (
        .CLK(CLK), .RESET(RESET), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .S_TDATA(S_TDATA), .S_TLAST(S_TLAST), .D0_O(D0_O), .D1_O(D1_O),
        .TX_O(TX_O), .UNDERRUN(UNDERRUN), .BUSY(BUSY)
    );

    oddr_tx_gearbox #(
        .DATA_W(8), .LSB_FIRST(1'b0), .INIT(1'b0), .PRE_BEATS(2), .PRE_PAT(2'b10)
    ) u_msb (
        .CLK(CLK), .RESET(RESET), .S_TVALID(S_TVALID), .S_TREADY(m_tready),
        .S_TDATA(S_TDATA), .S_TLAST(S_TLAST), .D0_O(m_d0), .D1_O(m_d1),
        .TX_O(m_tx), .UNDERRUN(m_underrun), .BUSY(m_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_lsb"}, 32'({S_TREADY, D0_O, D1_O, TX_O, BUSY, UNDERRUN}), 32'b100100);
        chk({tag, "_msb"}, 32'({m_tready, m_d0, m_d1, m_tx, m_busy, m_underrun}), 32'b100100);
    endtask

    // One clock: note any handshake, push its beats, then check beats due now.
    task automatic step();
        logic       x;
        logic [7:0] w;
        logic       l;
        int         off;
        beat_t      e;
        @(negedge CLK);
        x = S_TVALID && S_TREADY;
        w = S_TDATA;
        l = S_TLAST;
        @(posedge CLK);
        #1;
        cyc++;
        if (x) begin
            got     = 1;
            acc_cyc = cyc;
            off     = frame_open ? 0 : PRE_OFF;
            for (int k = 0; k < 4; k++) begin
                e.cyc = cyc + 1 + off + k;
                e.l   = {w[2*k], w[2*k+1]};
                e.m   = {w[7-2*k], w[6-2*k]};
                q.push_back(e);
            end
            frame_open = !l;
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("beat_lsb", 32'({e.cyc == cyc, D0_O, D1_O}), 32'({1'b1, e.l}));
            chk("beat_msb", 32'({m_d0, m_d1}), 32'(e.m));
            chk("beat_tx", 32'({TX_O, m_tx}), 32'd0);
        end
    endtask

    task automatic apply(input logic [7:0] w, input logic l);
        S_TVALID = 1'b1;
        S_TDATA  = w;
        S_TLAST  = l;
    endtask

    task automatic wait_accept();
        int n;
        got = 0;
        n   = 0;
        while (!got && n < 40) begin
            step();
            n++;
        end
        chk("accept", 32'(got), 32'd1);
        S_TVALID = 1'b0;
    endtask

    initial begin
        int a0, a, b, pulses;
        RESET    = 1'b1;
        S_TVALID = 1'b0;
        S_TDATA  = 8'h00;
        S_TLAST  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        idle_chk("in_reset");
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            idle_chk("idle");
        end

        // Single word, TLAST=1
        apply(8'hB4, 1'b1);
        wait_accept();
        a0 = acc_cyc;
        a  = a0 + PRE_OFF;
        while (cyc < a + 6) begin
            step();
            chk("single_tx", 32'(TX_O), 32'(cyc > a + 4));
            chk("single_ready", 32'(S_TREADY), 32'(cyc >= a + 4));
            chk("single_busy", 32'(BUSY), 32'(cyc < a + 4));
`ifdef ODDR_GBX_PREAMBLE_EN
            if (cyc <= a) chk("preamble", 32'({D0_O, D1_O, TX_O}), 32'b010);
`endif
        end

        // Back-to-back FF (TLAST=0) then 00 (TLAST=1)
        apply(8'hFF, 1'b0);
        wait_accept();
        a0 = acc_cyc;
        a  = a0 + PRE_OFF;
        apply(8'h00, 1'b1);
        got = 0;
        while (cyc < a + 4) begin
            chk("b2b_ready1", 32'(S_TREADY), 32'(cyc == a + 3));
            step();
        end
        chk("b2b_accept", 32'({got, acc_cyc == a + 4}), 32'b11);
        S_TVALID = 1'b0;
        while (cyc < a + 10) begin
            chk("b2b_ready2", 32'(S_TREADY), 32'(cyc >= a + 8));
            chk("b2b_tx", 32'(TX_O), 32'(!(cyc > a0 && cyc <= a + 8)));
            step();
        end

        // Underrun between AA (TLAST=0) and 55 (TLAST=1)
        apply(8'hAA, 1'b0);
        wait_accept();
        a      = acc_cyc + PRE_OFF;
        pulses = 0;
        while (cyc < a + 6) begin
            step();
            pulses += int'(UNDERRUN);
            chk("ur_pulse", 32'(UNDERRUN), 32'(cyc == a + 5));
            if (cyc >= a + 5) chk("hold_out", 32'({D0_O, D1_O, TX_O}), 32'b000);
        end
        apply(8'h55, 1'b1);
        wait_accept();
        b = acc_cyc;
        chk("hold_last", 32'({b == a + 7, D0_O, D1_O, TX_O, UNDERRUN}), 32'b10000);
        pulses += int'(UNDERRUN);
        while (cyc < b + 6) begin
            step();
            pulses += int'(UNDERRUN);
            chk("ur_tail_tx", 32'(TX_O), 32'(cyc > b + 4));
        end
        chk("ur_count", 32'(pulses), 32'd1);

        // Asynchronous reset in the middle of a word
        apply(8'h3C, 1'b1);
        wait_accept();
        S_TVALID = 1'b0;
        step();
        step();
        #2;
        RESET = 1'b1;
        #1;
        idle_chk("async_rst");
        q.delete();
        frame_open = 0;
        step();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            idle_chk("post_rst");
        end
        apply(8'h6D, 1'b1);
        wait_accept();
        a = acc_cyc + PRE_OFF;
        while (cyc < a + 6) begin
            step();
            chk("post_rst_tx", 32'(TX_O), 32'(cyc > a + 4));
        end

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
